// File: rtl/board_drawer.sv
// board_drawer: raster-scans the board RAM after each start request and
// streams every cell to the VGA adapter as a registered (x, y, colour, plot)
// pixel write. Requests that arrive while a frame is in flight collapse into
// a single queued frame, so a frame is never restarted or cut short.
module board_drawer #(
  parameter int          WIDTH     = 160,
  parameter int          HEIGHT    = 120,
  parameter logic [2:0]  BG_COLOUR = 3'b000
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        start,
  input  logic [2:0]  ram_q,
  output logic [14:0] ram_address,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
  localparam logic [6:0] Y_LAST = 7'(HEIGHT - 1);

  state_t     state;
  logic [7:0] cx;
  logic [6:0] cy;
  logic       flush_cnt;
  logic       pending;

  logic       v1;
  logic [7:0] x1;
  logic [6:0] y1;

  // The scan counters address the RAM directly; they sit at 0 outside SCAN.
  assign ram_address = {cx, cy};

  // Frame sequencer: walks the board row-major, drains the two-stage
  // pipeline, pulses done, and launches a queued frame if one is pending.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cx        <= 8'd0;
      cy        <= 7'd0;
      flush_cnt <= 1'b0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end
        end
        SCAN: begin
          if (start) pending <= 1'b1;
          if (cx == X_LAST) begin
            cx <= 8'd0;
            if (cy == Y_LAST) begin
              cy        <= 7'd0;
              flush_cnt <= 1'b0;
              state     <= FLUSH;
            end else begin
              cy <= cy + 7'd1;
            end
          end else begin
            cx <= cx + 8'd1;
          end
        end
        FLUSH: begin
          if (start) pending <= 1'b1;
          if (flush_cnt) begin
            flush_cnt <= 1'b0;
            state     <= DONE;
            busy      <= 1'b0;
            done      <= 1'b1;
          end else begin
            flush_cnt <= 1'b1;
          end
        end
        DONE: begin
          done    <= 1'b0;
          pending <= 1'b0;
          if (pending || start) begin
            state <= SCAN;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Pixel pipeline: stage 1 tracks the address the RAM is sampling, stage 2
  // pairs it with the returned data and substitutes the background colour.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      v1     <= 1'b0;
      x1     <= 8'd0;
      y1     <= 7'd0;
      plot   <= 1'b0;
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
    end else begin
      v1     <= (state == SCAN);
      x1     <= cx;
      y1     <= cy;
      plot   <= v1;
      x      <= x1;
      y      <= y1;
      colour <= (ram_q == 3'b000) ? BG_COLOUR : ram_q;
    end
  end

endmodule

// File: tb/tb_board_drawer.sv
// tb_board_drawer: directed checks of board_drawer. Instance a uses the
// default background, instance b uses background 3'b011 with its own RAM.
module tb_board_drawer;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_a, start_b;
  logic [2:0]  q_a, q_b;
  logic [14:0] addr_a, addr_b;
  logic [7:0]  x_a, x_b;
  logic [6:0]  y_a, y_b;
  logic [2:0]  colour_a, colour_b;
  logic        plot_a, plot_b, busy_a, busy_b, done_a, done_b;

  logic [2:0]  ram_a [0:32767];
  logic [2:0]  ram_b [0:32767];

  int checks = 0;
  int errors = 0;
  int rel;
  int plots_seen;

  // 50 MHz-style free-running clock
  always #5 clk = ~clk;

  // Board RAM models with one-cycle read latency
  always @(posedge clk) begin
    q_a <= ram_a[addr_a];
    q_b <= ram_b[addr_b];
  end

  board_drawer dut_a (
    .CLOCK_50(clk), .resetn(resetn), .start(start_a), .ram_q(q_a),
    .ram_address(addr_a), .x(x_a), .y(y_a), .colour(colour_a),
    .plot(plot_a), .busy(busy_a), .done(done_a)
  );

  board_drawer #(.WIDTH(160), .HEIGHT(120), .BG_COLOUR(3'b011)) dut_b (
    .CLOCK_50(clk), .resetn(resetn), .start(start_b), .ram_q(q_b),
    .ram_address(addr_b), .x(x_b), .y(y_b), .colour(colour_b),
    .plot(plot_b), .busy(busy_b), .done(done_b)
  );

  task automatic test_reset();
    resetn  = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({plot_a, busy_a, done_a} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL reset_ctrl got plot/busy/done=%b required 000", {plot_a, busy_a, done_a});
    end
    checks++;
    if ({addr_a, x_a, y_a, colour_a} !== 33'd0) begin
      errors++;
      $display("[TB] FAIL reset_data got addr=%h x=%0d y=%0d c=%b required all 0", addr_a, x_a, y_a, colour_a);
    end
    start_a = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_during_reset got busy=%b required 0", busy_a);
    end
    start_a = 1'b0;
    resetn  = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({plot_a, busy_a, done_a} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL idle_after_reset got plot/busy/done=%b required 000", {plot_a, busy_a, done_a});
    end
  endtask

  task automatic test_row_wrap();
    logic [14:0] exp_159, exp_160;
    int addr_bad;
    exp_159  = {8'd159, 7'd0};
    exp_160  = {8'd0, 7'd1};
    addr_bad = 0;
    plots_seen = 0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    rel = 0;
    checks++;
    if (busy_a !== 1'b1 || addr_a !== 15'd0) begin
      errors++;
      $display("[TB] FAIL scan_begin got busy=%b addr=%h required 1 0000", busy_a, addr_a);
    end
    while (rel < 160) begin
      @(negedge clk);
      rel++;
      if (plot_a === 1'b1) plots_seen++;
      if (rel == 159 && addr_a !== exp_159) addr_bad++;
      if (rel == 160 && addr_a !== exp_160) addr_bad++;
    end
    checks++;
    if (addr_bad !== 0) begin
      errors++;
      $display("[TB] FAIL row_wrap got %0d wrong addresses (now %h) required 0 (last %h)", addr_bad, addr_a, exp_160);
    end
  endtask

  task automatic test_reset_mid_frame();
    int bad;
    while (plots_seen < 5000 && rel < 6000) begin
      @(negedge clk);
      rel++;
      if (plot_a === 1'b1) plots_seen++;
    end
    checks++;
    if (rel !== 5001 || x_a !== 8'd39 || y_a !== 7'd31) begin
      errors++;
      $display("[TB] FAIL plot_5000 got rel=%0d x=%0d y=%0d required 5001 39 31", rel, x_a, y_a);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({plot_a, busy_a, done_a} !== 3'b000 || addr_a !== 15'd0) begin
      errors++;
      $display("[TB] FAIL async_reset got plot/busy/done=%b addr=%h required 000 0000", {plot_a, busy_a, done_a}, addr_a);
    end
    @(negedge clk);
    resetn = 1'b1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (plot_a !== 1'b0 || busy_a !== 1'b0 || done_a !== 1'b0) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("[TB] FAIL quiet_after_reset got %0d active cycles required 0", bad);
    end
  endtask

  task automatic test_basic_frame();
    int k, bad_a, bad_b, plots_a, plots_b, done_bad, range_bad;
    logic exp_p;
    logic [2:0] exp_ca, exp_cb;
    bad_a = 0; bad_b = 0; plots_a = 0; plots_b = 0; done_bad = 0; range_bad = 0;
    start_a = 1'b1;
    start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    rel = 0;
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b1 || plot_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_rise got busy_a=%b busy_b=%b plot=%b required 1 1 0", busy_a, busy_b, plot_a);
    end
    while (rel < 19203) begin
      @(negedge clk);
      rel++;
      k = rel - 2;
      exp_p  = (k >= 0 && k < 19200);
      exp_ca = (k == 0) ? 3'b001 : (k == 19199) ? 3'b110 : 3'b000;
      exp_cb = (k == 1125) ? 3'b111 : 3'b011;
      if (plot_a === 1'b1) plots_a++;
      if (plot_b === 1'b1) plots_b++;
      if (plot_a !== exp_p) bad_a++;
      else if (exp_p && (x_a !== 8'(k % 160) || y_a !== 7'(k / 160) || colour_a !== exp_ca)) bad_a++;
      if (plot_b !== exp_p) bad_b++;
      else if (exp_p && (x_b !== 8'(k % 160) || y_b !== 7'(k / 160) || colour_b !== exp_cb)) bad_b++;
      if (done_a !== (rel == 19202) || done_b !== (rel == 19202)) done_bad++;
      if (busy_a === 1'b1 && (addr_a[14:7] > 8'd159 || addr_a[6:0] > 7'd119)) range_bad++;
      if (busy_b === 1'b1 && (addr_b[14:7] > 8'd159 || addr_b[6:0] > 7'd119)) range_bad++;
      if (rel == 2) begin
        checks++;
        if (plot_a !== 1'b1 || x_a !== 8'd0 || y_a !== 7'd0 || colour_a !== 3'b001) begin
          errors++;
          $display("[TB] FAIL first_plot got p=%b x=%0d y=%0d c=%b required 1 0 0 001", plot_a, x_a, y_a, colour_a);
        end
      end
      if (rel == 1127) begin
        checks++;
        if (plot_b !== 1'b1 || x_b !== 8'd5 || y_b !== 7'd7 || colour_b !== 3'b111) begin
          errors++;
          $display("[TB] FAIL cell_5_7 got p=%b x=%0d y=%0d c=%b required 1 5 7 111", plot_b, x_b, y_b, colour_b);
        end
      end
      if (rel == 19201) begin
        checks++;
        if (plot_a !== 1'b1 || x_a !== 8'd159 || y_a !== 7'd119 || colour_a !== 3'b110) begin
          errors++;
          $display("[TB] FAIL last_plot got p=%b x=%0d y=%0d c=%b required 1 159 119 110", plot_a, x_a, y_a, colour_a);
        end
      end
      if (rel == 19202) begin
        checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b1) begin
          errors++;
          $display("[TB] FAIL frame_end got busy=%b done=%b required 0 1", busy_a, done_a);
        end
      end
      start_a = (rel == 100 || rel == 5000 || rel == 10000 || rel == 19200);
    end
    start_a = 1'b0;
    checks++;
    if (bad_a !== 0) begin
      errors++;
      $display("[TB] FAIL raster_a got %0d bad cycles required 0", bad_a);
    end
    checks++;
    if (bad_b !== 0) begin
      errors++;
      $display("[TB] FAIL raster_bg got %0d bad cycles required 0", bad_b);
    end
    checks++;
    if (plots_a !== 19200 || plots_b !== 19200) begin
      errors++;
      $display("[TB] FAIL plot_count got a=%0d b=%0d required 19200", plots_a, plots_b);
    end
    checks++;
    if (done_bad !== 0 || range_bad !== 0) begin
      errors++;
      $display("[TB] FAIL done_range got done_bad=%0d range_bad=%0d required 0 0", done_bad, range_bad);
    end
    checks++;
    if (busy_a !== 1'b1 || busy_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL queued_frame got busy_a=%b busy_b=%b required 1 0", busy_a, busy_b);
    end
  endtask

  task automatic test_start_collapsing();
    int k, bad, plots, first_rel, done_cnt;
    bad = 0; plots = 0; first_rel = -1; done_cnt = 0;
    while (rel < 38405) begin
      @(negedge clk);
      rel++;
      k = rel - 19205;
      if (plot_a === 1'b1) begin
        plots++;
        if (first_rel < 0) first_rel = rel;
      end
      if (plot_a !== (k >= 0 && k < 19200)) bad++;
      else if (k >= 0 && k < 19200 && (x_a !== 8'(k % 160) || y_a !== 7'(k / 160))) bad++;
      if (done_a === 1'b1) done_cnt++;
    end
    start_a = 1'b1;
    checks++;
    if (first_rel !== 19205) begin
      errors++;
      $display("[TB] FAIL second_first_plot got rel %0d required 19205", first_rel);
    end
    checks++;
    if (plots !== 19200 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL second_frame got plots=%0d bad=%0d required 19200 0", plots, bad);
    end
    checks++;
    if (done_cnt !== 1 || done_a !== 1'b1) begin
      errors++;
      $display("[TB] FAIL second_done got count=%0d done=%b required 1 1", done_cnt, done_a);
    end
  endtask

  task automatic test_start_in_done();
    int k, bad, plots, done_cnt, late;
    bad = 0; plots = 0; done_cnt = 0; late = 0;
    @(negedge clk);
    start_a = 1'b0;
    rel++;
    checks++;
    if (busy_a !== 1'b1 || done_a !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_start got busy=%b done=%b required 1 0", busy_a, done_a);
    end
    while (rel < 57708) begin
      @(negedge clk);
      rel++;
      k = rel - 38408;
      if (plot_a === 1'b1) plots++;
      if (plot_a !== (k >= 0 && k < 19200)) bad++;
      if (done_a === 1'b1) begin
        done_cnt++;
        if (rel !== 57608) bad++;
      end
      if (rel > 57608 && busy_a !== 1'b0) late++;
    end
    checks++;
    if (plots !== 19200 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL third_frame got plots=%0d bad=%0d required 19200 0", plots, bad);
    end
    checks++;
    if (done_cnt !== 1 || late !== 0) begin
      errors++;
      $display("[TB] FAIL no_extra_frame got done=%0d busy_late=%0d required 1 0", done_cnt, late);
    end
  endtask

  initial begin
    for (int i = 0; i < 32768; i++) begin
      ram_a[i] = 3'b000;
      ram_b[i] = 3'b000;
    end
    ram_a[{8'd0, 7'd0}]     = 3'b001;
    ram_a[{8'd159, 7'd119}] = 3'b110;
    ram_b[{8'd5, 7'd7}]     = 3'b111;
    test_reset();
    test_row_wrap();
    test_reset_mid_frame();
    test_basic_frame();
    test_start_collapsing();
    test_start_in_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
